control_sequencer: RTL and testbench
====================================

# control_sequencer

Hardwired control unit for the multi-cycle CPU datapath: a Moore state machine that sequences the per-cycle control strobes (fetch, then opcode-specific execute steps) that the `DataPath` consumes. It replaces hand-driven testbench strobes with one state per clock. It sits directly upstream of `DataPath`, reads back the instruction register contents, and drives every register-enable, bus-select and ALU-op input.

## Interface
- `OPW`, default 5: opcode field width, taken from `ir[31:27]`.
- `clock`, in, 1: single system clock; all state changes occur on its rising edge.
- `clear`, in, 1: asynchronous, active-low reset.
- `ir`, in, 32: current IR contents from `DataPath`.
- `stop`, in, 1: halt request, honoured at the next instruction boundary.
- `go`, in, 1: resume from HALTED.
- `PCout, Zlowout, MDRout, Csignout, BAout, Rout`, out, 1 each: bus drive selects.
- `PCin, MARin, MDRin, IRin, Yin, Zlowin, Rin`, out, 1 each: register load enables.
- `Gra, Grb`, out, 1 each: register-field select.
- `IncPC, ADD, AND, OR`, out, 1 each: ALU operation.
- `Read, Write, MD_read`, out, 1 each: memory strobes; `MD_read=1` selects memory into MDR.
- `MAR_clear`, out, 1: MAR clear.
- `run`, out, 1: high whenever the CPU is not halted or in reset.
- `illegal`, out, 1: one-cycle pulse on an undefined opcode.

## Operation
- Opcodes: ld=00000, ldi=00001, st=00010, addi=00011, andi=00100, ori=00101, nop=11010, halt=11011. Any other value is illegal and behaves as nop, with `illegal` pulsing in E3.
- States: RST, F0, F1, F2, E3..E7, HALTED. Outputs are a pure function of state and the `ir` opcode. Every output not listed for a state is 0.
- RST: `MAR_clear=1`. Next state is F0.
- F0: `PCout, MARin, IncPC, Zlowin`.
- F1: `Zlowout, PCin, Read, MDRin, MD_read`.
- F2: `MDRout, IRin`. From F2 the FSM always goes to E3.
- ld/ldi/st, address phase:
  - E3: `Grb, BAout, Yin`.
  - E4: `Csignout, ADD, Zlowin`.
- ldi: E5 drives `Zlowout, Gra, Rin`, then F0.
- ld:
  - E5: `Zlowout, MARin`.
  - E6: `Read, MD_read, MDRin`.
  - E7: `MDRout, Gra, Rin`, then F0.
- st:
  - E5: `Zlowout, MARin`.
  - E6: `Gra, Rout, MDRin`.
  - E7: `Write`, then F0.
- addi/andi/ori:
  - E3: `Grb, Rout, Yin`.
  - E4: `Csignout, Zlowin`, plus `ADD`, `AND` or `OR` respectively.
  - E5: `Zlowout, Gra, Rin`, then F0.
- nop/illegal: E3 drives no strobes, then F0.
- halt: E3 goes to HALTED.
- Instruction boundary: any transition into F0. If `stop` is sampled high at that edge, go to HALTED instead.
- HALTED: all strobes are 0 and `run=0`. `go` high moves to F0; `stop` and `go` both high means stay HALTED (stop wins).

## Timing
- `clear` low forces RST immediately, without waiting for a clock edge. Outputs then read `MAR_clear=1`, everything else 0, `run=0`. This holds mid-instruction; no partial writes complete after the assertion.
- First F0 occurs on the first rising edge after `clear` goes high.
- Cycle counts from F0, inclusive:
  - nop/illegal: 4.
  - ldi and ALU-immediate: 6.
  - ld and st: 8.
  - halt: 4, then HALTED.
- Opcode is decoded from `ir` during E3 and later states only. `ir` changes during F0–F2 are ignored.
- `run` is 1 in F0..E7 and 0 in RST and HALTED.
- Exactly one of `ADD/AND/OR/IncPC` is high per cycle, or none.
- Never both `Read` and `Write`.
- At most one bus driver per cycle.

## Structure
- Shared package `cpu_ctrl_pkg`:
  - opcode localparams;
  - state encoding (4-bit, one constant per state);
  - `OPW`.
- One combinational sub-module, `cs_decode`, maps opcode to class flags: `is_mem, is_ld, is_st, is_ldi, is_alu, is_halt, is_illegal` and a 2-bit ALU op. The FSM consumes only these flags.

## Test plan
- Reset, then `ir` = ldi (opcode 00001) → states RST,F0,F1,F2,E3,E4,E5,F0. E5 shows `Zlowout=Gra=Rin=1`. `run` rises at F0.
- ld (00000) → 8 cycles. E6 has `Read=MD_read=MDRin=1`. E7 has `MDRout=Gra=Rin=1`. `Write` is never high.
- st (00010) → E6 has `Gra=Rout=MDRin=1` with `MD_read=0`. E7 has `Write=1`. Next state is F0.
- andi (00100) then ori (00101) → in E4, `AND` then `OR` respectively, with `ADD=0`. E3 uses `Rout`, not `BAout`.
- Opcode 11111 → `illegal` pulses for one cycle in E3, no strobes, back to F0. Then halt (11011) → HALTED, `run=0`. `go` → F0.
- `stop` asserted during ld E5 → the instruction finishes E7, then HALTED. Also: `clear` pulled low in E4 → outputs go to reset values with no clock edge required.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// rtl/cpu_ctrl_pkg.sv - shared opcodes, state encoding and ALU op codes for the control sequencer
package cpu_ctrl_pkg;

  localparam int OPW = 5;

  localparam logic [OPW-1:0] OP_LD   = 5'b00000;
  localparam logic [OPW-1:0] OP_LDI  = 5'b00001;
  localparam logic [OPW-1:0] OP_ST   = 5'b00010;
  localparam logic [OPW-1:0] OP_ADDI = 5'b00011;
  localparam logic [OPW-1:0] OP_ANDI = 5'b00100;
  localparam logic [OPW-1:0] OP_ORI  = 5'b00101;
  localparam logic [OPW-1:0] OP_NOP  = 5'b11010;
  localparam logic [OPW-1:0] OP_HALT = 5'b11011;

  localparam logic [1:0] ALU_ADD  = 2'd0;
  localparam logic [1:0] ALU_AND  = 2'd1;
  localparam logic [1:0] ALU_OR   = 2'd2;
  localparam logic [1:0] ALU_NONE = 2'd3;

  typedef enum logic [3:0] {
    ST_RST    = 4'd0,
    ST_F0     = 4'd1,
    ST_F1     = 4'd2,
    ST_F2     = 4'd3,
    ST_E3     = 4'd4,
    ST_E4     = 4'd5,
    ST_E5     = 4'd6,
    ST_E6     = 4'd7,
    ST_E7     = 4'd8,
    ST_HALTED = 4'd9
  } state_e;

endpackage

// File: rtl/cs_decode.sv
// rtl/cs_decode.sv - maps an opcode to instruction class flags and an ALU op
module cs_decode
  import cpu_ctrl_pkg::*;
(
  input  logic [OPW-1:0] op_i,
  output logic           is_mem_o,
  output logic           is_ld_o,
  output logic           is_st_o,
  output logic           is_ldi_o,
  output logic           is_alu_o,
  output logic           is_halt_o,
  output logic           is_illegal_o,
  output logic [1:0]     alu_op_o
);

  always_comb begin
    is_mem_o     = 1'b0;
    is_ld_o      = 1'b0;
    is_st_o      = 1'b0;
    is_ldi_o     = 1'b0;
    is_alu_o     = 1'b0;
    is_halt_o    = 1'b0;
    is_illegal_o = 1'b0;
    alu_op_o     = ALU_NONE;
    case (op_i)
      OP_LD:   begin is_mem_o = 1'b1; is_ld_o  = 1'b1; alu_op_o = ALU_ADD; end
      OP_LDI:  begin is_mem_o = 1'b1; is_ldi_o = 1'b1; alu_op_o = ALU_ADD; end
      OP_ST:   begin is_mem_o = 1'b1; is_st_o  = 1'b1; alu_op_o = ALU_ADD; end
      OP_ADDI: begin is_alu_o = 1'b1; alu_op_o = ALU_ADD; end
      OP_ANDI: begin is_alu_o = 1'b1; alu_op_o = ALU_AND; end
      OP_ORI:  begin is_alu_o = 1'b1; alu_op_o = ALU_OR;  end
      OP_NOP:  ;
      OP_HALT: is_halt_o = 1'b1;
      default: is_illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// rtl/control_sequencer.sv - Moore control unit sequencing fetch and execute strobes for the datapath
module control_sequencer #(
  parameter int OPW = cpu_ctrl_pkg::OPW
) (
  input  logic        clock,
  input  logic        clear,
  input  logic [31:0] ir,
  input  logic        stop,
  input  logic        go,
  output logic        PCout,
  output logic        Zlowout,
  output logic        MDRout,
  output logic        Csignout,
  output logic        BAout,
  output logic        Rout,
  output logic        PCin,
  output logic        MARin,
  output logic        MDRin,
  output logic        IRin,
  output logic        Yin,
  output logic        Zlowin,
  output logic        Rin,
  output logic        Gra,
  output logic        Grb,
  output logic        IncPC,
  output logic        ADD,
  output logic        AND,
  output logic        OR,
  output logic        Read,
  output logic        Write,
  output logic        MD_read,
  output logic        MAR_clear,
  output logic        run,
  output logic        illegal
);

  import cpu_ctrl_pkg::*;

  state_e     state_q, state_d;
  state_e     boundary;
  logic       is_mem, is_ld, is_st, is_ldi, is_alu, is_halt, is_illegal;
  logic [1:0] alu_op;
  logic       ir_unused;

  assign ir_unused = ^ir[31-OPW:0];

  cs_decode u_decode (
    .op_i         (ir[31 -: OPW]),
    .is_mem_o     (is_mem),
    .is_ld_o      (is_ld),
    .is_st_o      (is_st),
    .is_ldi_o     (is_ldi),
    .is_alu_o     (is_alu),
    .is_halt_o    (is_halt),
    .is_illegal_o (is_illegal),
    .alu_op_o     (alu_op)
  );

  // Every entry into F0 is an instruction boundary where a pending stop diverts to HALTED.
  assign boundary = stop ? ST_HALTED : ST_F0;

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) state_q <= ST_RST;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    {PCout, Zlowout, MDRout, Csignout, BAout, Rout} = '0;
    {PCin, MARin, MDRin, IRin, Yin, Zlowin, Rin}    = '0;
    {Gra, Grb, IncPC, ADD, AND, OR}                 = '0;
    {Read, Write, MD_read, MAR_clear, illegal}      = '0;
    run = (state_q != ST_RST) && (state_q != ST_HALTED);

    case (state_q)
      ST_RST: begin
        MAR_clear = 1'b1;
        state_d   = boundary;
      end
      ST_F0: begin
        {PCout, MARin, IncPC, Zlowin} = '1;
        state_d = ST_F1;
      end
      ST_F1: begin
        {Zlowout, PCin, Read, MDRin, MD_read} = '1;
        state_d = ST_F2;
      end
      ST_F2: begin
        {MDRout, IRin} = '1;
        state_d = ST_E3;
      end
      ST_E3: begin
        if (is_mem)      {Grb, BAout, Yin} = '1;
        else if (is_alu) {Grb, Rout, Yin}  = '1;
        illegal = is_illegal;
        if (is_halt)               state_d = ST_HALTED;
        else if (is_mem || is_alu) state_d = ST_E4;
        else                       state_d = boundary;
      end
      ST_E4: begin
        {Csignout, Zlowin} = '1;
        ADD     = (is_mem || is_alu) && (alu_op == ALU_ADD);
        AND     = is_alu && (alu_op == ALU_AND);
        OR      = is_alu && (alu_op == ALU_OR);
        state_d = ST_E5;
      end
      ST_E5: begin
        if (is_ld || is_st) begin
          {Zlowout, MARin} = '1;
          state_d = ST_E6;
        end else begin
          {Zlowout, Gra, Rin} = {3{is_ldi || is_alu}};
          state_d = boundary;
        end
      end
      ST_E6: begin
        if (is_ld)      {Read, MD_read, MDRin} = '1;
        else if (is_st) {Gra, Rout, MDRin}     = '1;
        state_d = ST_E7;
      end
      ST_E7: begin
        if (is_ld)      {MDRout, Gra, Rin} = '1;
        else if (is_st) Write = 1'b1;
        state_d = boundary;
      end
      ST_HALTED: begin
        if (go && !stop) state_d = ST_F0;
      end
      default: state_d = ST_RST;
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
// tb/tb_control_sequencer.sv - randomized scoreboard bench for control_sequencer
module tb_control_sequencer;

  localparam logic [4:0] T_LD   = 5'b00000;
  localparam logic [4:0] T_LDI  = 5'b00001;
  localparam logic [4:0] T_ST   = 5'b00010;
  localparam logic [4:0] T_ADDI = 5'b00011;
  localparam logic [4:0] T_ANDI = 5'b00100;
  localparam logic [4:0] T_ORI  = 5'b00101;
  localparam logic [4:0] T_NOP  = 5'b11010;
  localparam logic [4:0] T_HALT = 5'b11011;

  typedef struct packed {
    logic PCout, Zlowout, MDRout, Csignout, BAout, Rout;
    logic PCin, MARin, MDRin, IRin, Yin, Zlowin, Rin;
    logic Gra, Grb;
    logic IncPC, ADD, AND, OR;
    logic Read, Write, MD_read;
    logic MAR_clear, run, illegal;
  } ctl_t;

  logic        clock, clear, stop, go;
  logic [31:0] ir;
  logic PCout, Zlowout, MDRout, Csignout, BAout, Rout;
  logic PCin, MARin, MDRin, IRin, Yin, Zlowin, Rin;
  logic Gra, Grb, IncPC, ADD, AND, OR;
  logic Read, Write, MD_read, MAR_clear, run, illegal;

  control_sequencer #(.OPW(5)) dut (
    .clock(clock), .clear(clear), .ir(ir), .stop(stop), .go(go),
    .PCout(PCout), .Zlowout(Zlowout), .MDRout(MDRout), .Csignout(Csignout),
    .BAout(BAout), .Rout(Rout), .PCin(PCin), .MARin(MARin), .MDRin(MDRin),
    .IRin(IRin), .Yin(Yin), .Zlowin(Zlowin), .Rin(Rin), .Gra(Gra), .Grb(Grb),
    .IncPC(IncPC), .ADD(ADD), .AND(AND), .OR(OR), .Read(Read), .Write(Write),
    .MD_read(MD_read), .MAR_clear(MAR_clear), .run(run), .illegal(illegal)
  );

  ctl_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  function automatic bit known_op(input logic [4:0] op);
    return op inside {T_LD, T_LDI, T_ST, T_ADDI, T_ANDI, T_ORI, T_NOP, T_HALT};
  endfunction

  function automatic int instr_len(input logic [4:0] op);
    if (op == T_LD || op == T_ST) return 8;
    if (op inside {T_LDI, T_ADDI, T_ANDI, T_ORI}) return 6;
    return 4;
  endfunction

  function automatic ctl_t rst_vec();
    ctl_t v = '0;
    v.MAR_clear = 1'b1;
    return v;
  endfunction

  // Strobes expected in cycle 'cyc' (0 = F0) of an instruction with opcode 'op'.
  function automatic ctl_t expect_at(input logic [4:0] op, input int cyc);
    ctl_t v = '0;
    bit addr = op inside {T_LD, T_LDI, T_ST};
    bit alu  = op inside {T_ADDI, T_ANDI, T_ORI};
    v.run = 1'b1;
    case (cyc)
      0: begin v.PCout = 1; v.MARin = 1; v.IncPC = 1; v.Zlowin = 1; end
      1: begin v.Zlowout = 1; v.PCin = 1; v.Read = 1; v.MDRin = 1; v.MD_read = 1; end
      2: begin v.MDRout = 1; v.IRin = 1; end
      3: begin
        if (addr)     begin v.Grb = 1; v.BAout = 1; v.Yin = 1; end
        else if (alu) begin v.Grb = 1; v.Rout = 1; v.Yin = 1; end
        else if (!known_op(op)) v.illegal = 1;
      end
      4: begin
        v.Csignout = 1; v.Zlowin = 1;
        v.ADD = addr || (op == T_ADDI);
        v.AND = (op == T_ANDI);
        v.OR  = (op == T_ORI);
      end
      5: begin
        v.Zlowout = 1;
        if (op == T_LDI || alu) begin v.Gra = 1; v.Rin = 1; end
        else v.MARin = 1;
      end
      6: begin
        if (op == T_LD) begin v.Read = 1; v.MD_read = 1; v.MDRin = 1; end
        else begin v.Gra = 1; v.Rout = 1; v.MDRin = 1; end
      end
      7: begin
        if (op == T_LD) begin v.MDRout = 1; v.Gra = 1; v.Rin = 1; end
        else v.Write = 1;
      end
      default: ;
    endcase
    return v;
  endfunction

  always @(negedge clock) begin
    ctl_t act, exp_v;
    act = {PCout, Zlowout, MDRout, Csignout, BAout, Rout,
           PCin, MARin, MDRin, IRin, Yin, Zlowin, Rin,
           Gra, Grb, IncPC, ADD, AND, OR,
           Read, Write, MD_read, MAR_clear, run, illegal};
    if (sb_q.size() > 0) begin
      exp_v = sb_q.pop_front();
      n_checks++;
      if (act !== exp_v) begin
        n_fail++;
        $display("FAIL ctl_vec t=%0t actual=%h required=%h ir_op=%b", $time, act, exp_v, ir[31:27]);
      end
    end
    n_checks++;
    if ($countones({PCout, Zlowout, MDRout, Csignout, BAout, Rout}) > 1) begin
      n_fail++;
      $display("FAIL one_bus_driver t=%0t actual=%0d required<=1", $time,
               $countones({PCout, Zlowout, MDRout, Csignout, BAout, Rout}));
    end
    n_checks++;
    if ($countones({IncPC, ADD, AND, OR}) > 1) begin
      n_fail++;
      $display("FAIL one_alu_op t=%0t actual=%0d required<=1", $time,
               $countones({IncPC, ADD, AND, OR}));
    end
    n_checks++;
    if (Read && Write) begin
      n_fail++;
      $display("FAIL read_write_excl t=%0t actual=1 required=0", $time);
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    clear = 1'b0;
    sb_q.push_back(rst_vec());
    step();
    clear = 1'b1;
    stop  = 1'b0;
    go    = 1'($urandom_range(0, 1));
    sb_q.push_back(rst_vec());
    step();
  endtask

  task automatic halt_wait(input int n);
    for (int i = 0; i < n; i++) begin
      sb_q.push_back('0);
      if (i == n - 1) begin
        go = 1'b1; stop = 1'b0;
      end else begin
        go   = 1'($urandom_range(0, 1));
        stop = go ? 1'b1 : 1'($urandom_range(0, 1));
      end
      step();
    end
  endtask

  // Called at the start of F0. stop_from >= 0 holds stop high from that cycle on.
  task automatic exec(input logic [4:0] op, input int stop_from, input int clear_at);
    int n;
    n = instr_len(op);
    for (int i = 0; i < n; i++) begin
      if (i < 2) ir = $urandom;
      else if (i == 2) ir = {op, 27'($urandom)};
      if (i == clear_at) begin
        sb_q.push_back(rst_vec());
        #1 clear = 1'b0;
        step();
        return;
      end
      sb_q.push_back(expect_at(op, i));
      go = 1'($urandom_range(0, 1));
      if (stop_from >= 0) stop = (i >= stop_from);
      else                stop = (i == n - 1) ? 1'b0 : 1'($urandom_range(0, 1));
      step();
    end
    if (op == T_HALT || stop_from >= 0) halt_wait($urandom_range(1, 4));
  endtask

  logic [4:0] rop;
  int         sel;
  int         budget;

  initial begin
    clear = 1'b0; stop = 1'b0; go = 1'b0; ir = '0;
    step();
    do_reset();
    exec(T_LDI,  -1, -1);
    exec(T_LD,   -1, -1);
    exec(T_ST,   -1, -1);
    exec(T_ANDI, -1, -1);
    exec(T_ORI,  -1, -1);
    exec(5'b11111, -1, -1);
    exec(T_HALT, -1, -1);
    exec(T_LD,    5, -1);
    exec(T_ADDI, -1, 4);
    do_reset();
    exec(T_NOP,  -1, -1);

    for (int k = 0; k < 60; k++) begin
      sel = $urandom_range(0, 8);
      case (sel)
        0: rop = T_LD;   1: rop = T_LDI;  2: rop = T_ST;
        3: rop = T_ADDI; 4: rop = T_ANDI; 5: rop = T_ORI;
        6: rop = T_NOP;  7: rop = T_HALT;
        default: begin
          rop = 5'($urandom);
          while (known_op(rop)) rop = 5'($urandom);
        end
      endcase
      if ($urandom_range(0, 5) == 0) exec(rop, instr_len(rop) - 1, -1);
      else                           exec(rop, -1, -1);
    end

    budget = 10;
    while (sb_q.size() != 0 && budget > 0) begin
      step();
      budget--;
    end
    n_checks++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain actual=%0d required=0", sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
